// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared EX-stage divider encodings and control levels.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle restoring divider for MIPS DIV/DIVU; {HI,LO} = {rem, quo}.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_neg_quo;
  logic                r_neg_rem;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_accept;
  logic                w_op1_neg;
  logic                w_op2_neg;
  logic [DATA_W-1:0]   w_op1_mag;
  logic [DATA_W-1:0]   w_op2_mag;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_trial;
  logic                w_borrow;
  logic [DATA_W-1:0]   w_quo_fin;
  logic [DATA_W-1:0]   w_rem_fin;

  assign w_accept  = (start_i == DivStart) && !annul_i;
  assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign w_op1_mag = w_op1_neg ? -opdata1_i : opdata1_i;
  assign w_op2_mag = w_op2_neg ? -opdata2_i : opdata2_i;

  // Partial remainder stays below the divisor, so the MSB of the
  // DATA_W+1-bit difference is exactly the borrow.
  assign w_shift  = {r_rem, r_quo[DATA_W-1]};
  assign w_trial  = w_shift - {1'b0, r_divisor};
  assign w_borrow = w_trial[DATA_W];

  assign w_quo_fin = r_neg_quo ? -r_quo : r_quo;
  assign w_rem_fin = r_neg_rem ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= DivFree;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DivFree:   if (w_accept) w_state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
      DivByZero: w_state_nxt = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)               w_state_nxt = DivFree;
        else if (r_cnt == LAST_CNT) w_state_nxt = DivEnd;
      end
      DivEnd:    if (start_i == DivStop) w_state_nxt = DivFree;
      default:   w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
          if (w_accept && opdata2_i != '0) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_op1_mag;
            r_divisor <= w_op2_mag;
            r_neg_quo <= w_op1_neg ^ w_op2_neg;
            r_neg_rem <= w_op1_neg;
          end
        end
        DivByZero: begin
          r_result <= '0;
          r_ready  <= annul_i ? DivResultNotReady : DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end else if (r_cnt != LAST_CNT) begin
            r_rem <= w_borrow ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], ~w_borrow};
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_result <= {w_rem_fin, w_quo_fin};
            r_ready  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready;

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed/random scoreboard bench for ex_div.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex_div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit perturb);
    int          stall_cnt;
    int          waited;
    bit          busy_nonzero;
    logic [63:0] exp;
    exp_q.push_back(model(sgn, a, b));
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    stall_cnt    = 0;
    waited       = 0;
    busy_nonzero = 1'b0;
    do begin
      @(negedge clk);
      waited++;
      if (stallreq) stall_cnt++;
      if (!ready && result !== 64'd0) busy_nonzero = 1'b1;
      if (perturb && waited == 5) begin
        op1        = ~a;
        op2        = a ^ 32'h1234_5679;
        signed_div = ~sgn;
      end
    end while (!ready && waited < 100);
    exp = exp_q.pop_front();
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_stall_cycles"}, 64'(stall_cnt), (b == 32'd0) ? 64'd2 : 64'd34);
    check({tag, "_busy_result_zero"}, 64'(busy_nonzero), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {result[62:0], ready}, {exp[62:0], 1'b1});
    end
    @(posedge clk); #1;
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_clear"}, {result[62:0], ready}, 64'd0);
  endtask

  initial begin
    bit saw_ready;
    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd0;
    op2        = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {result, 1'b0}, 65'd0 >> 1);
    check("reset_ready_stall", {ready, stallreq}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0, 1'b0);
    do_div("div_m7_2", 1'b1, -32'sd7, 32'd2, 0, 1'b0);
    do_div("div_7_m2", 1'b1, 32'd7, -32'sd2, 0, 1'b0);
    do_div("div_5_0", 1'b1, 32'd5, 32'd0, 0, 1'b0);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_div("hold_perturb", 1'b0, 32'd1000, 32'd13, 5, 1'b1);

    // Annul partway through the iterations; the flushed op must never report.
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    op1        = 32'd1000;
    op2        = 32'd3;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    check("annul_no_ready", 64'(saw_ready), 64'd0);
    check("annul_result", result, 64'd0);
    do_div("after_annul", 1'b0, 32'd9, 32'd3, 0, 1'b0);

    @(posedge clk); #1;
    start = 1'b1;
    op1   = 32'd12345;
    op2   = 32'd67;
    repeat (15) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs", {result[62:0], ready}, 64'd0);
    check("rst_mid_stall", 64'(stallreq), 64'd0);
    rst = 1'b0;
    do_div("after_rst", 1'b0, 32'd123456, 32'd789, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd5;
      do_div("random", 1'(i % 3 == 0), ra, rb, i % 2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle integer divider for the EX stage, implementing MIPS DIV/DIVU. It produces one quotient bit per cycle using restoring division. While it works, it holds a stall request toward the pipeline controller, which in turn drives the `stall` vector that freezes the PC/IF/ID/ID-EX registers. It returns remainder and quotient as a 64-bit {HI, LO} pair to EX for the HI/LO write path.

## Interface
Parameters:
- `DATA_W`, 32, operand width; result is 2*DATA_W; iteration counter is clog2(DATA_W)+1 bits.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  DATA_W  dividend; sampled only on acceptance.
- `opdata2_i`  in  DATA_W  divisor; sampled only on acceptance.
- `start_i`  in  1  EX requests a division; held high until ready_o is seen.
- `annul_i`  in  1  flush (exception or branch); abandons the current operation.
- `result_o`  out  2*DATA_W  [2*DATA_W-1:DATA_W] = remainder (HI), [DATA_W-1:0] = quotient (LO).
- `ready_o`  out  1  result_o valid.
- `stallreq_o`  out  1  combinational: start_i & ~ready_o; OR-ed into the controller's stall sources.

## Operation
- State machine states: FREE, BYZERO, ON, END. Reset → FREE, result_o = 0, ready_o = 0, counter = 0.
- FREE:
  - start_i=1, annul_i=0, divisor==0 → BYZERO.
  - start_i=1, annul_i=0, divisor≠0 → ON. Operand magnitudes are latched; if signed_div_i and the operand MSB is set, the two's complement is taken. Counter cleared.
  - Otherwise stay in FREE; ready_o = 0, result_o = 0.
- BYZERO → END with result_o = 0 and ready_o = 1. Annul in BYZERO → FREE.
- ON, annul_i=0, counter < DATA_W:
  - Shift the partial remainder left one bit and bring in the next dividend MSB.
  - Trial-subtract the divisor magnitude. If there is no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - counter += 1.
- ON, counter == DATA_W:
  - Quotient is negated iff signed_div_i & (op1[MSB] ^ op2[MSB]).
  - Remainder is negated iff signed_div_i & op1[MSB].
  - Load result_o, set ready_o = 1, go to END.
- ON, annul_i=1 → FREE immediately. ready_o stays 0, result_o = 0, and no result is ever presented.
- END holds result_o and ready_o while start_i = 1. When start_i = 0, go to FREE and clear ready_o and result_o next edge. annul_i is ignored in END.
- Sign of operation uses signed_div_i as sampled at acceptance, not the live value.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. No trap.
- Operand or signed_div_i changes after acceptance have no effect.

## Timing
- Edge 0 is the first edge with start_i=1 in FREE.
- Normal division: ON at edge 0, iterations on edges 1..DATA_W, finalize on edge DATA_W+1. ready_o is high after edge DATA_W+1, i.e. 34 cycles for DATA_W=32.
- Divide by zero: ready_o is high after edge 1 (2 cycles).
- stallreq_o rises in the same cycle start_i rises and falls in the cycle ready_o rises. EX drops start_i the following cycle.
- ready_o is registered. result_o changes only on the finalize edge, the BYZERO→END edge, or the clear edge.
- Back-to-back divisions: at least one FREE cycle between operations, because END→FREE requires start_i = 0.
- rst mid-operation overrides everything. Outputs are at reset values after that edge.
- Simultaneous start_i and annul_i in FREE: not accepted.

## Structure
- The shared defines package gains:
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd`;
  - `DivResultReady` / `DivResultNotReady`;
  - `DivStart` / `DivStop`.
- DATA_W+1-bit trial subtract and conditional negate stay inline; there is no sub-module.
- EX instantiates ex_div alongside the ALU and forwards stallreq_o to the pipeline controller.

## Test plan
- Unsigned: DIVU 100 / 7 → after 34 cycles ready_o=1, result_o = {32'd2, 32'd14}. stallreq_o is high for exactly 34 cycles.
- Signed: DIV -7 / 2 → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. DIV 7 / -2 → {32'd1, 32'hFFFFFFFD}.
- Zero divisor: DIV 5 / 0 → ready_o=1 two cycles after start, result_o = 0. Overflow: 0x80000000 / 0xFFFFFFFF signed → {0, 32'h80000000}.
- Annul: assert annul_i at iteration 10 → FREE next edge, ready_o never rises. A fresh 9/3 afterward gives {0, 3}.
- Hold/release: keep start_i high 5 cycles past ready_o → result_o stable. Drop start_i → ready_o=0, result_o=0 next edge. Change opdata mid-run → result unchanged.
- Reset: assert rst during ON → all outputs 0, state FREE. An immediate new start completes in 34 cycles.
